potato_exerciser: RTL and testbench

Traffic source and checker for the 32-bit valid/ready increment pipeline. It drives the pipeline's input side with a sequence of words, applies a programmable backpressure pattern on the pipeline's output side, and checks that every returned word equals the sent word + 1, in order. It sits beside the pipeline in board bring-up and self-test builds and reports pass/fail, error count, first bad word, and timeout.

---
 rtl/potato_exerciser.sv | 174 +++++++++++++++++
 tb/tb_potato_exerciser.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/potato_exerciser.sv
// potato_exerciser: traffic source/checker for a 32-bit valid/ready +1 pipeline.
// Sends seed..seed+count-1 on tx, expects each +1 in order on rx, and reports
// the result on busy/done/pass/timeout/err_cnt/first_err_data.
module potato_exerciser #(
  parameter int           CNT_W        = 16,
  parameter int           MAX_INFLIGHT = 4,
  parameter logic [7:0]   RDY_PATTERN  = 8'hFF,
  parameter int           TIMEOUT      = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_cnt,
  output logic [31:0]      first_err_data,
  output logic             tx_val,
  output logic [31:0]      tx_data,
  input  logic             tx_rdy,
  input  logic             rx_val,
  input  logic [31:0]      rx_data,
  output logic             rx_rdy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_INF = CNT_W'(MAX_INFLIGHT);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [31:0]      r_seed;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_sent;
  logic [CNT_W-1:0] r_recvd;
  logic [CNT_W-1:0] r_err_cnt;
  logic [31:0]      r_first_err;
  logic             r_pass;
  logic             r_timeout;
  logic [WD_W-1:0]  r_wdog;
  logic [2:0]       r_phase;
  logic             r_tx_val;
  logic [31:0]      r_tx_data;

  logic             w_run;
  logic             w_rx_rdy;
  logic             w_tx_fire;
  logic             w_rx_fire;
  logic             w_fin;
  logic             w_wd_exp;
  logic [CNT_W-1:0] w_sent_nxt;
  logic [31:0]      w_exp;
  logic             w_mismatch;
  logic             w_tx_ok;
  logic             w_busy;
  logic             w_done;

  assign w_run      = (r_state == S_RUN);
  assign w_rx_rdy   = w_run & RDY_PATTERN[r_phase];
  assign w_tx_fire  = w_run & r_tx_val & tx_rdy;
  assign w_rx_fire  = w_run & rx_val & w_rx_rdy;
  assign w_fin      = (r_recvd == r_count);
  assign w_wd_exp   = (r_wdog == WD_MAX);
  assign w_sent_nxt = r_sent + CNT_W'(w_tx_fire);
  assign w_exp      = r_seed + 32'(r_recvd) + 32'd1;
  assign w_mismatch = (rx_data != w_exp);
  // Count limit uses the post-beat sent so a word is never offered twice;
  // inflight uses the registered recvd, so a freed slot shows one edge later.
  assign w_tx_ok    = (w_sent_nxt < r_count) &&
                      ((w_sent_nxt - r_recvd) < MAX_INF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_nxt = S_RUN;
      S_RUN:  if (w_fin || w_wd_exp) w_nxt = S_DONE;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_RUN:  w_busy = 1'b1;
      S_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed      <= '0;
      r_count     <= '0;
      r_sent      <= '0;
      r_recvd     <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_wdog      <= '0;
      r_phase     <= '0;
      r_tx_val    <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_tx_val <= 1'b0;
          if (start) begin
            r_seed      <= seed;
            r_count     <= count;
            r_sent      <= '0;
            r_recvd     <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_wdog      <= '0;
            r_phase     <= '0;
            r_tx_data   <= seed;
          end
        end
        S_RUN: begin
          r_sent  <= w_sent_nxt;
          r_recvd <= r_recvd + CNT_W'(w_rx_fire);
          r_phase <= r_phase + 3'd1;
          if (w_tx_fire || w_rx_fire) r_wdog <= '0;
          else                        r_wdog <= r_wdog + WD_W'(1);
          if (w_rx_fire && w_mismatch) begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            if (r_err_cnt == '0) r_first_err <= rx_data;
          end
          if (w_fin || w_wd_exp) begin
            r_tx_val  <= 1'b0;
            r_pass    <= w_fin & (r_err_cnt == '0);
            r_timeout <= ~w_fin;
          end else begin
            r_tx_val  <= w_tx_ok;
            r_tx_data <= r_seed + 32'(w_sent_nxt);
          end
        end
        S_DONE: r_tx_val <= 1'b0;
        default: r_tx_val <= 1'b0;
      endcase
    end
  end

  assign busy           = w_busy;
  assign done           = w_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_cnt        = r_err_cnt;
  assign first_err_data = r_first_err;
  assign tx_val         = r_tx_val;
  assign tx_data        = r_tx_data;
  assign rx_rdy         = w_rx_rdy;

endmodule

// File: tb/tb_potato_exerciser.sv
// tb_potato_exerciser: two exerciser instances (default and 2-inflight/alternating
// rx_rdy) looped through a 2-deep +1 pipeline model with error injection.
module tb_potato_exerciser;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] seed = '0;
  logic [15:0] count = '0;

  logic sel = 1'b0;
  logic inj = 1'b0;
  logic hold = 1'b0;
  logic rnd_en = 1'b0;
  logic [31:0] cur_seed = '0;
  int ret_base = 0;

  logic a_busy, a_done, a_pass, a_to, a_tx_val, a_rx_rdy;
  logic [15:0] a_err;
  logic [31:0] a_first, a_tx_data;
  logic b_busy, b_done, b_pass, b_to, b_tx_val, b_rx_rdy;
  logic [15:0] b_err;
  logic [31:0] b_first, b_tx_data;

  logic        p_tx_rdy, p_rx_val;
  logic [31:0] p_rx_data;

  logic c_busy, c_done, c_pass, c_to, c_tx_val, c_rx_rdy;
  logic [15:0] c_err;
  logic [31:0] c_first, c_tx_data;

  assign c_busy    = sel ? b_busy    : a_busy;
  assign c_done    = sel ? b_done    : a_done;
  assign c_pass    = sel ? b_pass    : a_pass;
  assign c_to      = sel ? b_to      : a_to;
  assign c_err     = sel ? b_err     : a_err;
  assign c_first   = sel ? b_first   : a_first;
  assign c_tx_val  = sel ? b_tx_val  : a_tx_val;
  assign c_tx_data = sel ? b_tx_data : a_tx_data;
  assign c_rx_rdy  = sel ? b_rx_rdy  : a_rx_rdy;

  potato_exerciser u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .seed(seed), .count(count),
    .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_to),
    .err_cnt(a_err), .first_err_data(a_first),
    .tx_val(a_tx_val), .tx_data(a_tx_data), .tx_rdy(p_tx_rdy & ~sel),
    .rx_val(p_rx_val & ~sel), .rx_data(p_rx_data), .rx_rdy(a_rx_rdy)
  );

  potato_exerciser #(.MAX_INFLIGHT(2), .RDY_PATTERN(8'b01010101)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .seed(seed), .count(count),
    .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_to),
    .err_cnt(b_err), .first_err_data(b_first),
    .tx_val(b_tx_val), .tx_data(b_tx_data), .tx_rdy(p_tx_rdy & sel),
    .rx_val(p_rx_val & sel), .rx_data(p_rx_data), .rx_rdy(b_rx_rdy)
  );

  // 2-deep +1 pipeline model
  logic [31:0] m_d0, m_d1;
  int m_n, m_ret;
  logic m_rnd;

  assign p_tx_rdy  = (m_n < 2) && m_rnd && !hold;
  assign p_rx_val  = (m_n > 0);
  assign p_rx_data = (m_d0 + 32'd1) ^
                     {31'd0, (inj && (m_ret - ret_base) == 1)};

  always @(posedge clk or negedge rst_n) begin : pipe
    int n;
    logic [31:0] d0, d1;
    logic tf, rf;
    if (!rst_n) begin
      m_n <= 0; m_ret <= 0; m_rnd <= 1'b1;
      m_d0 <= '0; m_d1 <= '0;
    end else begin
      tf = c_tx_val && p_tx_rdy;
      rf = p_rx_val && c_rx_rdy;
      n = m_n; d0 = m_d0; d1 = m_d1;
      if (rf) begin d0 = d1; n = n - 1; end
      if (tf) begin
        if (n == 0) d0 = c_tx_data;
        else        d1 = c_tx_data;
        n = n + 1;
      end
      m_n <= n; m_d0 <= d0; m_d1 <= d1;
      m_ret <= m_ret + (rf ? 1 : 0);
      m_rnd <= rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // protocol monitor on the selected instance
  int mon_tx, mon_rx, mon_max, mon_bad, mon_k, rdy_viol, hold_viol;
  logic prev_stall;
  logic [31:0] prev_data;

  always @(posedge clk) begin : mon
    logic tf, rf;
    logic [7:0] pv;
    if (start_a || start_b) begin
      mon_tx = 0; mon_rx = 0; mon_max = 0; mon_bad = 0;
      mon_k = 0; rdy_viol = 0; hold_viol = 0; prev_stall = 1'b0;
    end else if (c_busy) begin
      tf = c_tx_val && p_tx_rdy;
      rf = p_rx_val && c_rx_rdy;
      if (tf) begin
        if (c_tx_data != cur_seed + 32'(mon_tx)) mon_bad++;
        mon_tx++;
      end
      if (rf) mon_rx++;
      if (mon_tx - mon_rx > mon_max) mon_max = mon_tx - mon_rx;
      pv = sel ? 8'h55 : 8'hFF;
      if (c_rx_rdy != pv[mon_k % 8]) rdy_viol++;
      mon_k++;
      if (prev_stall && (!c_tx_val || c_tx_data != prev_data)) hold_viol++;
      prev_stall = c_tx_val && !p_tx_rdy;
      prev_data = c_tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run(input logic s, input logic [31:0] sd,
                     input logic [15:0] cn, input logic inj_i,
                     input logic hold_i, input logic rnd_i,
                     input logic exp_pass, input logic [15:0] exp_err,
                     input logic exp_to, input logic [31:0] exp_first,
                     input string nm);
    int cyc;
    int stall_bad;
    int lim;
    lim = s ? 2 : 4;
    stall_bad = 0;
    @(negedge clk);
    sel = s; inj = inj_i; hold = hold_i; rnd_en = rnd_i;
    seed = sd; count = cn; cur_seed = sd; ret_base = m_ret;
    if (s) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    chk({nm, "_txval_n"}, 32'(c_tx_val), 0);
    @(negedge clk);
    chk({nm, "_txval_n1"}, 32'(c_tx_val), 32'(cn != 0));
    chk({nm, "_busy_n1"}, 32'(c_busy), 32'(cn != 0));
    cyc = 0;
    while (!c_done && cyc < 3000) begin
      if (hold_i && c_busy && !(c_tx_val && c_tx_data == sd)) stall_bad++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_done_seen"}, 32'(c_done), 1);
    if (cn == 0) chk({nm, "_done_lat"}, cyc, 0);
    if (exp_to)  chk({nm, "_to_lat"}, cyc, 1024);
    if (hold_i)  chk({nm, "_stall_hold"}, stall_bad, 0);
    chk({nm, "_pass"}, 32'(c_pass), 32'(exp_pass));
    chk({nm, "_err"}, 32'(c_err), 32'(exp_err));
    chk({nm, "_timeout"}, 32'(c_to), 32'(exp_to));
    chk({nm, "_busy_done"}, 32'(c_busy), 0);
    chk({nm, "_sent"}, mon_tx, exp_to ? 0 : 32'(cn));
    chk({nm, "_txdata"}, mon_bad, 0);
    chk({nm, "_hold"}, hold_viol, 0);
    chk({nm, "_rdy_pat"}, rdy_viol, 0);
    chk({nm, "_inflight"}, 32'(mon_max <= lim), 1);
    if (exp_err != 0) chk({nm, "_first"}, c_first, exp_first);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(c_done), 0);
    chk({nm, "_pass_sticky"}, 32'(c_pass), 32'(exp_pass));
    chk({nm, "_to_sticky"}, 32'(c_to), 32'(exp_to));
  endtask

  typedef struct {
    logic        s;
    logic [31:0] sd;
    logic [15:0] cn;
    logic        inj;
    logic        hold;
    logic        exp_pass;
    logic [15:0] exp_err;
    logic        exp_to;
    logic [31:0] exp_first;
    string       nm;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b0, 32'h10, 16'd4, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 32'h0, "basic"};
    tbl[1] = '{1'b0, 32'hFFFFFFFE, 16'd3, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 32'h0, "wrap"};
    tbl[2] = '{1'b0, 32'h10, 16'd4, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 32'h13, "inject"};
    tbl[3] = '{1'b0, 32'h10, 16'd2, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 32'h0, "tmo"};
    tbl[4] = '{1'b0, 32'h10, 16'd0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 32'h0, "cnt0"};
    tbl[5] = '{1'b1, 32'h10, 16'd20, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 32'h0, "alt"};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_pass", 32'(a_pass), 0);
    chk("rst_to", 32'(a_to), 0);
    chk("rst_txval", 32'(a_tx_val), 0);
    chk("rst_rxrdy", 32'(a_rx_rdy), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_first", a_first, 0);
    chk("rst_txdata", a_tx_data, 0);
    chk("rst_b_busy", 32'(b_busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run(tbl[i].s, tbl[i].sd, tbl[i].cn, tbl[i].inj, tbl[i].hold, 1'b0,
          tbl[i].exp_pass, tbl[i].exp_err, tbl[i].exp_to, tbl[i].exp_first,
          tbl[i].nm);

    // reset mid-run, then a clean rerun
    @(negedge clk);
    sel = 1'b1; inj = 1'b1; hold = 1'b0; rnd_en = 1'b0;
    seed = 32'h10; count = 16'd20; cur_seed = 32'h10; ret_base = m_ret;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(b_busy), 1);
    chk("mid_err", 32'(b_err), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_txval", 32'(b_tx_val), 0);
    chk("arst_rxrdy", 32'(b_rx_rdy), 0);
    chk("arst_busy", 32'(b_busy), 0);
    chk("arst_err", 32'(b_err), 0);
    chk("arst_first", b_first, 0);
    chk("arst_txdata", b_tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    inj = 1'b0;
    run(tbl[5].s, tbl[5].sd, tbl[5].cn, 1'b0, 1'b0, 1'b0,
        1'b1, 16'd0, 1'b0, 32'h0, "rerun");

    // randomized runs against the pipeline model
    for (int r = 0; r < 8; r++) begin
      logic        rs, ri;
      logic [31:0] rsd;
      logic [15:0] rcn;
      logic [15:0] re;
      rs  = 1'($urandom_range(0, 1));
      ri  = 1'($urandom_range(0, 1));
      rsd = $urandom;
      rcn = 16'($urandom_range(1, 24));
      re  = (ri && rcn >= 2) ? 16'd1 : 16'd0;
      run(rs, rsd, rcn, ri, 1'b0, 1'b1, re == 0, re, 1'b0,
          (rsd + 32'd2) ^ 32'd1, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
